// File: rtl/clk_ratio_det_pkg.sv
// Shared definitions for the clock ratio detector: FSM encoding and counter limits.
package clk_ratio_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    // Saturation value of a width-bit counter (all ones); never wrapped past.
    function automatic logic [31:0] cnt_sat(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/clk_ratio_det_sync_edge_det.sv
// Two-flop synchronizer for the divided clock plus a third flop for rise/fall detection.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], i_d};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/clk_ratio_det.sv
// Measures period (and optionally high time) of i_div_clk in i_ref_clk cycles, with lock/timeout.
// Define CLK_RATIO_DUTY_EN to build the high-time counter behind o_high_cnt.
module clk_ratio_det
    import clk_ratio_det_pkg::*;
#(
    parameter int unsigned Div_Ratio_Width = 8,
    parameter int unsigned Lock_Count      = 2
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst_n,
    input  logic                       i_en,
    input  logic                       i_div_clk,
    output logic [Div_Ratio_Width-1:0] o_ratio,
    output logic [Div_Ratio_Width-1:0] o_high_cnt,
    output logic                       o_valid,
    output logic                       o_lock,
    output logic                       o_timeout
);

    localparam int unsigned W       = Div_Ratio_Width;
    localparam int unsigned MATCH_W = $clog2(Lock_Count + 1);
    localparam logic [W-1:0] CNT_SAT = W'(cnt_sat(W));
    localparam logic [MATCH_W-1:0] LOCK_N = MATCH_W'(Lock_Count);

    logic rise;
    logic fall;

    sync_edge_det u_sync (
        .i_clk   (i_ref_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_div_clk),
        .rise    (rise),
        .fall    (fall)
    );

    state_t               state_q, state_d;
    logic [W-1:0]         cnt_q, cnt_d;
    logic [W-1:0]         ratio_q, ratio_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic                 have_prev_q, have_prev_d;
    logic                 valid_q, valid_d;
    logic                 lock_q, lock_d;
    logic                 tout_q, tout_d;

    logic                 run;
    logic                 meas;
    logic                 tout_hit;
    logic [MATCH_W-1:0]   match_nxt;
    logic                 lock_reach;

    assign run      = i_en && (state_q != ST_IDLE);
    assign meas     = rise && ((state_q == ST_MEASURE) || (state_q == ST_LOCKED));
    assign tout_hit = !rise && (cnt_q == CNT_SAT);

    // Match tracking: first measurement after idle/timeout has nothing to compare against.
    always_comb begin
        match_nxt = MATCH_W'(1);
        if (have_prev_q && (cnt_q == ratio_q)) begin
            match_nxt = (match_q >= LOCK_N) ? match_q : match_q + MATCH_W'(1);
        end
    end
    assign lock_reach = (match_nxt >= LOCK_N);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_EDGE;
                ST_WAIT_EDGE: if (rise) state_d = ST_MEASURE;
                ST_MEASURE: begin
                    if (meas && lock_reach) state_d = ST_LOCKED;
                    else if (tout_hit)      state_d = ST_WAIT_EDGE;
                end
                ST_LOCKED: begin
                    if (meas && !lock_reach) state_d = ST_MEASURE;
                    else if (tout_hit)       state_d = ST_WAIT_EDGE;
                end
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of counters and registered outputs; a rise always wins over saturation.
    always_comb begin
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        match_d     = match_q;
        have_prev_d = have_prev_q;
        valid_d     = 1'b0;
        lock_d      = lock_q;
        tout_d      = tout_q;
        if (!run) begin
            cnt_d       = '0;
            match_d     = '0;
            have_prev_d = 1'b0;
            lock_d      = 1'b0;
            tout_d      = 1'b0;
        end else begin
            if (rise)          cnt_d = W'(1);
            else if (!tout_hit) cnt_d = cnt_q + W'(1);
            if (meas) begin
                ratio_d     = cnt_q;
                valid_d     = 1'b1;
                match_d     = match_nxt;
                have_prev_d = 1'b1;
                lock_d      = lock_reach;
            end else if (tout_hit) begin
                tout_d      = 1'b1;
                lock_d      = 1'b0;
                match_d     = '0;
                have_prev_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            ratio_q     <= '0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            match_q     <= match_d;
            have_prev_q <= have_prev_d;
            valid_q     <= valid_d;
            lock_q      <= lock_d;
            tout_q      <= tout_d;
        end
    end

`ifdef CLK_RATIO_DUTY_EN
    logic [W-1:0] hi_cnt_q, hi_lat_q, high_q;
    logic         hi_run_q;

    // High time counts from a rise until the following fall, then waits for the next measurement.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_cnt_q <= '0;
            hi_lat_q <= '0;
            hi_run_q <= 1'b0;
            high_q   <= '0;
        end else if (!run) begin
            hi_cnt_q <= '0;
            hi_lat_q <= '0;
            hi_run_q <= 1'b0;
        end else begin
            if (rise) begin
                hi_cnt_q <= W'(1);
                hi_run_q <= 1'b1;
            end else if (fall && hi_run_q) begin
                hi_lat_q <= hi_cnt_q;
                hi_run_q <= 1'b0;
            end else if (hi_run_q && (hi_cnt_q != CNT_SAT)) begin
                hi_cnt_q <= hi_cnt_q + W'(1);
            end
            if (meas) high_q <= hi_lat_q;
        end
    end

    assign o_high_cnt = high_q;
`else
    logic unused_fall;
    assign unused_fall = fall;
    assign o_high_cnt  = '0;
`endif

    assign o_ratio   = ratio_q;
    assign o_valid   = valid_q;
    assign o_lock    = lock_q;
    assign o_timeout = tout_q;

endmodule

// File: tb/tb_clk_ratio_det.sv
// Directed self-checking bench for clk_ratio_det (W=8, Lock_Count=2).
module tb_clk_ratio_det;

    localparam int unsigned W = 8;
`ifdef CLK_RATIO_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         div;
    logic [W-1:0] o_ratio;
    logic [W-1:0] o_high_cnt;
    logic         o_valid;
    logic         o_lock;
    logic         o_timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int v_ratio[$];
    int v_high[$];
    int v_lock[$];
    int v_cyc[$];

    clk_ratio_det #(.Div_Ratio_Width(W), .Lock_Count(2)) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_div_clk  (div),
        .o_ratio    (o_ratio),
        .o_high_cnt (o_high_cnt),
        .o_valid    (o_valid),
        .o_lock     (o_lock),
        .o_timeout  (o_timeout)
    );

    always #5 clk = ~clk;

    function automatic int exp_hi(input int h);
        return DUTY ? h : 0;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (o_valid === 1'b1) begin
            v_ratio.push_back(int'(o_ratio));
            v_high.push_back(int'(o_high_cnt));
            v_lock.push_back(int'(o_lock));
            v_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_q();
        v_ratio.delete();
        v_high.delete();
        v_lock.delete();
        v_cyc.delete();
    endtask

    // Whole periods starting with a rising edge; each period ends low.
    task automatic drive(input int per, input int hi, input int nper);
        for (int n = 0; n < nper; n++) begin
            for (int p = 0; p < per; p++) begin
                div = (p < hi);
                tick();
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({o_ratio, o_high_cnt, o_valid, o_lock, o_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {o_ratio, o_high_cnt, o_valid, o_lock, o_timeout});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({o_valid, o_lock, o_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000", {o_valid, o_lock, o_timeout});
        end
    endtask

    task automatic test_div4();
        en = 1'b1;
        clear_q();
        drive(4, 2, 5);
        checks++;
        if (v_ratio.size() != 4) begin errors++; $display("FAIL div4_count: got %0d expected 4", v_ratio.size()); end
        checks++;
        if (v_ratio[0] !== 4) begin errors++; $display("FAIL div4_ratio: got %0d expected 4", v_ratio[0]); end
        checks++;
        if (v_high[0] !== exp_hi(2)) begin errors++; $display("FAIL div4_high: got %0d expected %0d", v_high[0], exp_hi(2)); end
        checks++;
        if (v_lock[0] !== 0) begin errors++; $display("FAIL div4_lock_first: got %0d expected 0", v_lock[0]); end
        checks++;
        if (v_lock[2] !== 1) begin errors++; $display("FAIL div4_lock_third: got %0d expected 1", v_lock[2]); end
    endtask

    task automatic test_ratio_change();
        clear_q();
        drive(6, 3, 4);
        checks++;
        if (v_ratio.size() != 4) begin errors++; $display("FAIL chg_count: got %0d expected 4", v_ratio.size()); end
        checks++;
        if (v_ratio[1] !== 6) begin errors++; $display("FAIL chg_ratio: got %0d expected 6", v_ratio[1]); end
        checks++;
        if (v_lock[1] !== 0) begin errors++; $display("FAIL chg_unlock: got %0d expected 0", v_lock[1]); end
        checks++;
        if (v_high[1] !== exp_hi(3)) begin errors++; $display("FAIL chg_high: got %0d expected %0d", v_high[1], exp_hi(3)); end
        checks++;
        if (v_lock[2] !== 1) begin errors++; $display("FAIL chg_relock: got %0d expected 1", v_lock[2]); end
    endtask

    task automatic test_div5();
        clear_q();
        drive(5, 3, 4);
        checks++;
        if (v_ratio[3] !== 5) begin errors++; $display("FAIL div5_ratio: got %0d expected 5", v_ratio[3]); end
        checks++;
        if (v_high[3] !== exp_hi(3)) begin errors++; $display("FAIL div5_high: got %0d expected %0d", v_high[3], exp_hi(3)); end
        checks++;
        if (v_lock[1] !== 0 || v_lock[3] !== 1) begin
            errors++; $display("FAIL div5_lock: got %0d/%0d expected 0/1", v_lock[1], v_lock[3]);
        end
    endtask

    task automatic test_enable();
        clear_q();
        en = 1'b0;
        drive(5, 3, 2);
        checks++;
        if (v_ratio.size() != 0) begin errors++; $display("FAIL dis_valid: got %0d expected 0", v_ratio.size()); end
        checks++;
        if ({o_lock, o_timeout} !== 2'b00) begin errors++; $display("FAIL dis_flags: got %b expected 00", {o_lock, o_timeout}); end
        checks++;
        if (o_ratio !== 8'd5) begin errors++; $display("FAIL dis_ratio_hold: got %0d expected 5", o_ratio); end
        checks++;
        if (int'(o_high_cnt) !== exp_hi(3)) begin errors++; $display("FAIL dis_high_hold: got %0d expected %0d", o_high_cnt, exp_hi(3)); end
        en = 1'b1;
        drive(5, 3, 4);
        checks++;
        if (v_ratio.size() != 3) begin errors++; $display("FAIL en_count: got %0d expected 3", v_ratio.size()); end
        checks++;
        if (v_lock[0] !== 0 || v_lock[2] !== 1) begin
            errors++; $display("FAIL en_relock: got %0d/%0d expected 0/1", v_lock[0], v_lock[2]);
        end
    endtask

    task automatic test_timeout();
        int  cv;
        bit  got;
        cv  = v_cyc[v_cyc.size() - 1];
        got = 1'b0;
        div = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (o_timeout === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL timeout_seen: got 0 expected 1 within 400 cycles");
        end else begin
            checks++;
            if (cyc - cv !== 255) begin errors++; $display("FAIL timeout_latency: got %0d expected 255", cyc - cv); end
        end
        checks++;
        if (o_lock !== 1'b0) begin errors++; $display("FAIL timeout_lock: got %b expected 0", o_lock); end
        checks++;
        if (o_ratio !== 8'd5) begin errors++; $display("FAIL timeout_ratio: got %0d expected 5", o_ratio); end
        clear_q();
        drive(3, 1, 3);
        checks++;
        if (v_ratio.size() != 2 || v_ratio[0] !== 3) begin
            errors++; $display("FAIL post_tout_meas: got n=%0d r=%0d expected n=2 r=3", v_ratio.size(), v_ratio[0]);
        end
        checks++;
        if (v_high[0] !== exp_hi(1)) begin errors++; $display("FAIL post_tout_high: got %0d expected %0d", v_high[0], exp_hi(1)); end
        checks++;
        if (o_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", o_timeout); end
    endtask

    task automatic test_reset_mid();
        drive(3, 1, 2);
        div = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ratio, o_high_cnt, o_valid, o_lock, o_timeout} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", {o_ratio, o_high_cnt, o_valid, o_lock, o_timeout});
        end
        div = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        drive(3, 1, 3);
        checks++;
        if (v_ratio.size() != 2) begin errors++; $display("FAIL rst_count: got %0d expected 2", v_ratio.size()); end
        checks++;
        if (v_ratio[0] !== 3) begin errors++; $display("FAIL rst_ratio: got %0d expected 3", v_ratio[0]); end
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", o_timeout); end
    endtask

    task automatic test_saturation();
        clear_q();
        drive(255, 1, 3);
        checks++;
        if (v_ratio.size() != 3 || v_ratio[1] !== 255 || v_ratio[2] !== 255) begin
            errors++; $display("FAIL sat_edge_ratio: got n=%0d r=%0d expected n=3 r=255", v_ratio.size(), v_ratio[1]);
        end
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $display("FAIL sat_edge_no_tout: got %b expected 0", o_timeout); end
        clear_q();
        drive(256, 1, 2);
        checks++;
        if (v_ratio.size() != 1) begin errors++; $display("FAIL over_range_count: got %0d expected 1", v_ratio.size()); end
        checks++;
        if (o_timeout !== 1'b1) begin errors++; $display("FAIL over_range_tout: got %b expected 1", o_timeout); end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        div   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_div4();
        test_ratio_change();
        test_div5();
        test_enable();
        test_timeout();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
